tbck_dec: RTL and testbench



---
 rtl/tbck_dec_pkg.sv | 15 +
 rtl/tbck_ptr_mux.sv | 25 ++
 rtl/tbck_dec.sv | 108 ++++++++++
 tb/tb_tbck_dec.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/tbck_dec_pkg.sv
// Shared types and constants for the Viterbi traceback stage.
package tbck_dec_pkg;

  localparam int ST_W          = 2;
  localparam int TBCK_LEN_DEF  = 8;

  typedef logic [ST_W-1:0] st_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fsm_t;

endpackage

// File: rtl/tbck_ptr_mux.sv
// Predecessor selector: picks the survivor pointer belonging to the current node.
module tbck_ptr_mux
  import tbck_dec_pkg::*;
(
  input  logic [ST_W-1:0] node,
  input  logic [ST_W-1:0] prv_00,
  input  logic [ST_W-1:0] prv_01,
  input  logic [ST_W-1:0] prv_10,
  input  logic [ST_W-1:0] prv_11,
  output logic [ST_W-1:0] prv
);

  // 4:1 select on the current trellis state
  always_comb begin
    prv = prv_00;
    unique case (node)
      2'b00: prv = prv_00;
      2'b01: prv = prv_01;
      2'b10: prv = prv_10;
      2'b11: prv = prv_11;
      default: prv = prv_00;
    endcase
  end

endmodule

// File: rtl/tbck_dec.sv
// Traceback stage of the 4-state (K=3) Viterbi decoder.
// Optional build macro TBCK_DEC_REVERSE_EN: newest decoded bit lands in the
// MSB of data_out instead of the LSB.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | waiting for en_tbck; loads sel_node on start
//   S_RUN  | one traceback step per cycle, TBCK_LEN steps total
//   S_DONE | data_out valid, done_flag high; leaves when en_tbck drops
module tbck_dec
  import tbck_dec_pkg::*;
#(
  parameter int TBCK_LEN = TBCK_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_tbck,
  input  logic [ST_W-1:0]     bck_prv_st_00,
  input  logic [ST_W-1:0]     bck_prv_st_01,
  input  logic [ST_W-1:0]     bck_prv_st_10,
  input  logic [ST_W-1:0]     bck_prv_st_11,
  input  logic [ST_W-1:0]     sel_node,
  output logic [TBCK_LEN-1:0] data_out,
  output logic                done_flag
);

  localparam int CNT_W = (TBCK_LEN > 1) ? $clog2(TBCK_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TBCK_LEN - 1);

  fsm_t                state;
  fsm_t                state_nxt;
  st_t                 node;
  st_t                 node_prv;
  logic [CNT_W-1:0]    cnt;
  logic [TBCK_LEN-1:0] sr;
  logic [TBCK_LEN-1:0] sr_nxt;
  logic                bit_dec;
  logic                last_step;

  tbck_ptr_mux u_ptr_mux (
    .node   (node),
    .prv_00 (bck_prv_st_00),
    .prv_01 (bck_prv_st_01),
    .prv_10 (bck_prv_st_10),
    .prv_11 (bck_prv_st_11),
    .prv    (node_prv)
  );

  // The state MSB is the input bit that drove the trellis into this state.
  assign bit_dec   = node[ST_W-1];
  assign last_step = (cnt == CNT_LAST);
  assign done_flag = (state == S_DONE);

  // Packing of the newly traced bit into the shift register
  always_comb begin
    sr_nxt = sr;
`ifdef TBCK_DEC_REVERSE_EN
    sr_nxt = {sr[TBCK_LEN-2:0], bit_dec};
`else
    sr_nxt = {bit_dec, sr[TBCK_LEN-1:1]};
`endif
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic; en_tbck is ignored while running
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (en_tbck)   state_nxt = S_RUN;
      S_RUN:   if (last_step) state_nxt = S_DONE;
      S_DONE:  if (!en_tbck)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Traceback datapath: node walk, step counter, shift register, output word
  always_ff @(posedge clk) begin
    if (rst) begin
      node     <= '0;
      cnt      <= '0;
      sr       <= '0;
      data_out <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (en_tbck) begin
            node <= sel_node;
            cnt  <= '0;
            sr   <= '0;
          end
        end
        S_RUN: begin
          node <= node_prv;
          cnt  <= cnt + CNT_W'(1);
          sr   <= sr_nxt;
          if (last_step) data_out <= sr_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tbck_dec.sv
// Directed, table-driven bench for the Viterbi traceback stage.
module tb_tbck_dec;

  localparam int LEN = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           en_tbck;
  logic [1:0]     p00, p01, p10, p11;
  logic [1:0]     sel_node;
  logic [LEN-1:0] data_out;
  logic           done_flag;

  int checks   = 0;
  int failures = 0;

  tbck_dec #(.TBCK_LEN(LEN)) dut (
    .clk           (clk),
    .rst           (rst),
    .en_tbck       (en_tbck),
    .bck_prv_st_00 (p00),
    .bck_prv_st_01 (p01),
    .bck_prv_st_10 (p10),
    .bck_prv_st_11 (p11),
    .sel_node      (sel_node),
    .data_out      (data_out),
    .done_flag     (done_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] sel;
    logic [1:0] q00, q01, q10, q11;
    logic [7:0] exp_fwd;
    logic [7:0] exp_rev;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pick(input logic [7:0] fwd, input logic [7:0] rev);
`ifdef TBCK_DEC_REVERSE_EN
    return rev;
`else
    return fwd;
`endif
  endfunction

  // One full run; en_tbck optionally dropped after drop_at steps
  task automatic run_one(input string name, input logic [1:0] sel,
                         input logic [7:0] exp, input int drop_at);
    logic [7:0] prev;
    prev     = data_out;
    sel_node = sel;
    en_tbck  = 1'b1;
    tick();
    sel_node = ~sel;
    for (int k = 1; k <= LEN; k++) begin
      tick();
      if (k == drop_at) en_tbck = 1'b0;
      if (k < LEN) begin
        chk({name, "_done_low"}, {31'd0, done_flag}, 32'd0);
        chk({name, "_data_hold"}, {24'd0, data_out}, {24'd0, prev});
      end
    end
    chk({name, "_done_high"}, {31'd0, done_flag}, 32'd1);
    chk({name, "_data"}, {24'd0, data_out}, {24'd0, exp});
  endtask

  initial begin
    logic [1:0] steps [7];
    logic [7:0] held;

    vecs[0] = '{"ones",  2'b11, 2'b01, 2'b10, 2'b01, 2'b11, 8'hFF, 8'hFF};
    vecs[1] = '{"alt",   2'b00, 2'b01, 2'b10, 2'b01, 2'b11, 8'h54, 8'h2A};
    vecs[2] = '{"first", 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 8'h01, 8'h80};
    vecs[3] = '{"tail",  2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 8'hFE, 8'h7F};
    vecs[4] = '{"mix",   2'b01, 2'b10, 2'b00, 2'b11, 2'b01, 8'hCC, 8'h33};

    steps[0] = 2'b10; steps[1] = 2'b00; steps[2] = 2'b11; steps[3] = 2'b01;
    steps[4] = 2'b10; steps[5] = 2'b10; steps[6] = 2'b00;

    // Reset with en_tbck held high: nothing starts
    rst = 1'b1; en_tbck = 1'b1; sel_node = 2'b11;
    p00 = 2'b01; p01 = 2'b10; p10 = 2'b01; p11 = 2'b11;
    tick(); tick();
    chk("rst_data", {24'd0, data_out}, 32'd0);
    chk("rst_done", {31'd0, done_flag}, 32'd0);
    en_tbck = 1'b0;
    rst = 1'b0;
    tick();
    chk("post_rst_done", {31'd0, done_flag}, 32'd0);

    // Reset at step 5 aborts with no output update
    sel_node = 2'b11; en_tbck = 1'b1;
    tick();
    en_tbck = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_data", {24'd0, data_out}, 32'd0);
    chk("abort_done", {31'd0, done_flag}, 32'd0);
    for (int k = 0; k < LEN + 2; k++) tick();
    chk("abort_idle_done", {31'd0, done_flag}, 32'd0);
    chk("abort_idle_data", {24'd0, data_out}, 32'd0);
    run_one("after_abort", 2'b11, 8'hFF, 0);
    en_tbck = 1'b0;
    tick();
    chk("after_abort_exit", {31'd0, done_flag}, 32'd0);

    // Table of complete runs
    for (int v = 0; v < 5; v++) begin
      p00 = vecs[v].q00; p01 = vecs[v].q01; p10 = vecs[v].q10; p11 = vecs[v].q11;
      run_one(vecs[v].name, vecs[v].sel, pick(vecs[v].exp_fwd, vecs[v].exp_rev), 0);
      en_tbck = 1'b0;
      tick();
      chk({vecs[v].name, "_exit"}, {31'd0, done_flag}, 32'd0);
    end

    // Drop en_tbck at step 3: run completes, single-cycle done pulse
    p00 = 2'b01; p01 = 2'b10; p10 = 2'b01; p11 = 2'b11;
    run_one("drop3", 2'b00, pick(8'h54, 8'h2A), 3);
    tick();
    chk("drop3_pulse_end", {31'd0, done_flag}, 32'd0);
    tick();
    chk("drop3_stay_idle", {31'd0, done_flag}, 32'd0);
    chk("drop3_data_kept", {24'd0, data_out}, {24'd0, pick(8'h54, 8'h2A)});

    // Hold en_tbck high in DONE: flag stays, no restart
    p00 = 2'b00; p01 = 2'b00; p10 = 2'b00; p11 = 2'b00;
    run_one("hold", 2'b10, pick(8'h01, 8'h80), 0);
    p00 = 2'b11; p01 = 2'b11; p10 = 2'b11; p11 = 2'b11;
    held = data_out;
    for (int k = 0; k < LEN + 3; k++) begin
      tick();
      chk("hold_done", {31'd0, done_flag}, 32'd1);
    end
    chk("hold_data", {24'd0, data_out}, {24'd0, held});
    en_tbck = 1'b0;
    tick();
    chk("hold_exit", {31'd0, done_flag}, 32'd0);

    // Pointers changed every step to follow successive trellis columns
    sel_node = 2'b01; en_tbck = 1'b1;
    tick();
    sel_node = 2'b10;
    for (int k = 0; k < LEN; k++) begin
      if (k < 7) begin
        p00 = steps[k]; p01 = steps[k]; p10 = steps[k]; p11 = steps[k];
      end else begin
        p00 = 2'b00; p01 = 2'b00; p10 = 2'b00; p11 = 2'b00;
      end
      tick();
    end
    chk("perstep_done", {31'd0, done_flag}, 32'd1);
    chk("perstep_data", {24'd0, data_out}, {24'd0, pick(8'h6A, 8'h56)});
    en_tbck = 1'b0;
    tick();
    chk("perstep_exit", {31'd0, done_flag}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
